fifo_burst_reader: RTL and testbench

- Read-side controller for the synchronous FIFO (`fifo_sync`).
- On a start command it pops exactly `len` words through the FIFO's `rinc`/`rdata`/`rempty` port.
- It absorbs the FIFO's one-cycle registered read latency in an internal 3-entry skid queue.
- It presents the words on a valid/ready stream with `m_last` on the final word, then pulses `done`.

---
 rtl/fifo_burst_reader_pkg.sv | 28 ++
 rtl/fifo_burst_skid_q.sv | 60 ++++++
 rtl/fifo_burst_reader.sv | 141 ++++++++++++++
 tb/tb_fifo_burst_reader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// fifo_burst_reader_pkg
// Shared types and constants for the FIFO burst reader: the controller
// state encoding, the skid-queue depth and the width of its occupancy count.
// No ports (package).

package fifo_burst_reader_pkg;

    // Skid queue depth. One entry covers the registered FIFO read latency,
    // the other two let the stream run at full rate while rinc is gated on
    // occupancy rather than on m_ready.
    localparam int Q_DEPTH = 3;

    // Bits needed to count 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int QCW = cnt_width(Q_DEPTH);

    typedef logic [QCW-1:0] qcnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_burst_skid_q.sv
// fifo_burst_skid_q
// Small register queue (Q_DEPTH entries) that holds FIFO words between the
// registered FIFO read and the output stream. Entry 0 is always the head;
// a pop shifts the remaining entries down by one.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push, wdata    write one word (caller guarantees the queue is not full)
//   pop            remove the head word (caller guarantees count != 0)
//   head           current head word (0 after reset)
//   count          number of stored words

module fifo_burst_skid_q
    import fifo_burst_reader_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DSIZE-1:0] wdata,
    input  logic             pop,
    output logic [DSIZE-1:0] head,
    output qcnt_t            count
);

    logic [DSIZE-1:0] mem [Q_DEPTH];
    qcnt_t            wr_idx;

    // On a simultaneous pop the entries shift down, so the new word lands
    // one slot lower than the current count.
    always_comb begin
        wr_idx = pop ? (count - qcnt_t'(1)) : count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < Q_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pop) begin
                for (int i = 0; i < Q_DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (push) begin
                mem[wr_idx] <= wdata;
            end
            case ({push, pop})
                2'b10:   count <= count + qcnt_t'(1);
                2'b01:   count <= count - qcnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[0];

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
// Read-side burst controller for fifo_sync. A start command with length len
// pops exactly len words from the FIFO, buffers them in a 3-entry skid queue
// to absorb the FIFO's one-cycle read latency, and streams them out with
// m_last on the final word, followed by a one-cycle done pulse.
//
// Optional build macro: FIFO_BURST_READER_STALL_CNT_EN adds stall_cnt, a
// saturating count of RUN cycles spent waiting on an empty FIFO while words
// remain to be issued; it clears on reset and at each new burst.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start, len                 burst request and word count (sampled in IDLE)
//   busy, done                 not-IDLE flag, completion pulse
//   fifo_rinc/rdata/rempty     FIFO read port (rdata valid cycle after rinc)
//   m_valid/m_ready/m_data     output stream
//   m_last                     marks the final word of the burst
//   dbg_state                  current controller state (state_t encoding)
//   stall_cnt                  empty-FIFO stall counter (macro builds only)
//
// Stream handshake: a word transfers on every rising edge where m_valid and
// m_ready are both high. m_valid never depends on m_ready, and once m_valid
// is raised m_data and m_last hold until the word transfers.

module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int LSIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LSIZE-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             fifo_rinc,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_rempty,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last,
    output logic [1:0]       dbg_state
`ifdef FIFO_BURST_READER_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    state_t           state, state_nx;
    logic [LSIZE-1:0] issue_rem;
    logic [LSIZE-1:0] deliver_rem;
    logic             inflight;
    qcnt_t            q_count;
    logic             pop;
    logic             accept_start;
    logic [QCW:0]     occupancy;

    assign accept_start = (state == IDLE) && start;

    // Words already committed to the queue: stored plus the one whose FIFO
    // read is still in flight. Gating on this (not on m_ready) keeps rinc
    // free of any combinational path from the stream side.
    assign occupancy = {1'b0, q_count} + {{QCW{1'b0}}, inflight};
    assign fifo_rinc = (state == RUN) && !fifo_rempty && (issue_rem != '0)
                       && (occupancy < (QCW+1)'(Q_DEPTH));

    assign m_valid   = (q_count != '0);
    assign pop       = m_valid && m_ready;
    assign m_last    = m_valid && (deliver_rem == LSIZE'(1));
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

    fifo_burst_skid_q #(
        .DSIZE (DSIZE)
    ) u_skid_q (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .wdata (fifo_rdata),
        .pop   (pop),
        .head  (m_data),
        .count (q_count)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (pop && (deliver_rem == LSIZE'(1))) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            issue_rem   <= '0;
            deliver_rem <= '0;
            inflight    <= 1'b0;
        end else begin
            state    <= state_nx;
            // A reset clears inflight, so a word read just before it is dropped.
            inflight <= fifo_rinc;
            if (accept_start) begin
                issue_rem   <= len;
                deliver_rem <= len;
            end else begin
                if (fifo_rinc) begin
                    issue_rem <= issue_rem - LSIZE'(1);
                end
                if (pop) begin
                    deliver_rem <= deliver_rem - LSIZE'(1);
                end
            end
        end
    end

`ifdef FIFO_BURST_READER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || accept_start) begin
            stall_cnt <= '0;
        end else if ((state == RUN) && fifo_rempty && (issue_rem != '0)
                     && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
`timescale 1ns/1ps
// tb_fifo_burst_reader
// Drives fifo_burst_reader from a behavioural FIFO and checks the stream
// against the words written into that FIFO, in order.

module tb_fifo_burst_reader;

    localparam int DSIZE = 8;
    localparam int LSIZE = 8;
    localparam int MEMSZ = 1024;
    localparam int QMAX  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LSIZE-1:0] len;
    logic             busy;
    logic             done;
    logic             fifo_rinc;
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_rempty;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic             m_last;
    logic [1:0]       dbg_state;
`ifdef FIFO_BURST_READER_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural FIFO: registered read data, empty flag from pointers.
    logic [DSIZE-1:0] fifo_mem [MEMSZ];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    logic             fifo_flush = 1'b0;
    int               rinc_cnt = 0;

    // Scoreboard: every word written to the FIFO, in order.
    logic [DSIZE-1:0] exp_q[$];

    fifo_burst_reader #(
        .DSIZE (DSIZE),
        .LSIZE (LSIZE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .fifo_rinc   (fifo_rinc),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .dbg_state   (dbg_state)
`ifdef FIFO_BURST_READER_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    // ---------------- clock / FIFO model ----------------
    always #5 clk = ~clk;

    assign fifo_rempty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rinc && !fifo_rempty) begin
            fifo_rdata <= fifo_mem[rd_ptr % MEMSZ];
            rd_ptr     <= rd_ptr + 1;
        end
        if (fifo_rinc) begin
            rinc_cnt <= rinc_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic fifo_write(input logic [DSIZE-1:0] d);
        fifo_mem[wr_ptr % MEMSZ] = d;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(d);
    endtask

    // Runs one burst. mode: 0 ready always, 1 ready 1,0,0 repeating,
    // 2 random. late_n words are written at cycle late_c after start.
    task automatic run_burst(input int blen, input int mode, input int late_c,
                             input int late_n, input bit restart,
                             input bit chk_lat, input string name);
        int   c = 0;
        int   acc = 0;
        int   last_acc_c = -1;
        int   first_v_c = -1;
        int   rinc_base;
        int   stalls = 0;
        int   budget;
        int   ph = 0;
        int   exp_done_c;
        bit   prev_hold = 1'b0;
        logic exp_last;
        logic [DSIZE-1:0] prev_data = '0;
        budget = blen * 6 + 60;
        @(negedge clk);
        start = 1'b1;
        len   = LSIZE'(blen);
        rinc_base = rinc_cnt;
        forever begin
            @(negedge clk);
            if (restart && c == 3) begin
                start = 1'b1;
                len   = LSIZE'(3);
            end else begin
                start = 1'b0;
            end
            if (c == late_c) begin
                for (int i = 0; i < late_n; i++) fifo_write(8'($urandom_range(0, 255)));
            end
            #1;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (ph % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;

            checks++;
            if (fifo_rinc && fifo_rempty) begin
                errors++;
                $display("FAIL %s rinc_while_empty: rinc=%b rempty=%b required rinc=0", name, fifo_rinc, fifo_rempty);
            end
            checks++;
            if ((rinc_cnt - rinc_base) - acc > QMAX) begin
                errors++;
                $display("FAIL %s buffered: outstanding=%0d required <= %0d", name, (rinc_cnt - rinc_base) - acc, QMAX);
            end
            if (blen != 0 && acc < blen && fifo_rempty && (rinc_cnt - rinc_base) < blen) stalls++;

            if (done) begin
                exp_done_c = (blen == 0) ? 0 : last_acc_c + 1;
                checks++;
                if (c != exp_done_c) begin
                    errors++;
                    $display("FAIL %s done_timing: cycle=%0d required %0d", name, c, exp_done_c);
                end
                checks++;
                if (acc != blen) begin
                    errors++;
                    $display("FAIL %s beat_count: got %0d required %0d", name, acc, blen);
                end
                checks++;
                if (rinc_cnt - rinc_base != blen) begin
                    errors++;
                    $display("FAIL %s rinc_total: got %0d required %0d", name, rinc_cnt - rinc_base, blen);
                end
                checks++;
                if (m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s valid_at_done: got %b required 0", name, m_valid);
                end
`ifdef FIFO_BURST_READER_STALL_CNT_EN
                checks++;
                if (stall_cnt !== 16'(stalls)) begin
                    errors++;
                    $display("FAIL %s stall_cnt: got %0d required %0d", name, stall_cnt, stalls);
                end
`endif
                @(negedge clk);
                #1;
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_pulse: done=%b busy=%b required 0 0", name, done, busy);
                end
                break;
            end

            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy: got %b required 1 at cycle %0d", name, busy, c);
            end
            if (prev_hold) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    errors++;
                    $display("FAIL %s hold: valid=%b data=%h required 1 %h", name, m_valid, m_data, prev_data);
                end
            end
            if (m_valid) begin
                if (first_v_c < 0) begin
                    first_v_c = c;
                    if (chk_lat) begin
                        checks++;
                        if (c != 2) begin
                            errors++;
                            $display("FAIL %s latency: first valid at %0d required 2", name, c);
                        end
                    end
                end
                checks++;
                if (acc >= blen || exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_beat: data=%h after %0d beats, required none", name, m_data, acc);
                end else if (m_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL %s data: beat %0d got %h required %h", name, acc, m_data, exp_q[0]);
                end
                exp_last = (acc == blen - 1);
                checks++;
                if (m_last !== exp_last) begin
                    errors++;
                    $display("FAIL %s last: beat %0d got %b required %b", name, acc, m_last, exp_last);
                end
                if (m_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    acc++;
                    last_acc_c = c;
                end
            end else begin
                checks++;
                if (m_last !== 1'b0) begin
                    errors++;
                    $display("FAIL %s last_without_valid: got %b required 0", name, m_last);
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            c++;
            if (c > budget) begin
                errors++;
                $display("FAIL %s timeout: no done after %0d cycles, required done", name, budget);
                break;
            end
        end
        m_ready = 1'b0;
        start   = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic check_reset_values(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 ||
            fifo_rinc !== 1'b0 || m_data !== 8'h00 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL %s reset_values: busy=%b done=%b valid=%b last=%b rinc=%b data=%h state=%0d required all 0",
                     name, busy, done, m_valid, m_last, fifo_rinc, m_data, dbg_state);
        end
`ifdef FIFO_BURST_READER_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL %s reset_stall_cnt: got %0d required 0", name, stall_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        check_reset_values("reset");
    endtask

    task automatic test_basic();
        for (int i = 0; i < 5; i++) fifo_write(8'h11 + 8'(i));
        run_burst(5, 0, -1, 0, 1'b0, 1'b1, "basic");
    endtask

    task automatic test_zero_len();
        run_burst(0, 0, -1, 0, 1'b0, 1'b0, "zero_len");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) fifo_write(8'($urandom_range(0, 255)));
        run_burst(4, 0, 10, 2, 1'b0, 1'b1, "stall");
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) fifo_write(8'($urandom_range(0, 255)));
        run_burst(8, 1, -1, 0, 1'b0, 1'b1, "backpressure");
    endtask

    task automatic test_restart();
        for (int i = 0; i < 6; i++) fifo_write(8'($urandom_range(0, 255)));
        run_burst(6, 0, -1, 0, 1'b1, 1'b1, "restart");
    endtask

    task automatic test_random();
        for (int n = 0; n < 5; n++) begin
            int blen;
            int pre;
            blen = $urandom_range(1, 20);
            pre  = $urandom_range(0, blen);
            for (int i = 0; i < pre; i++) fifo_write(8'($urandom_range(0, 255)));
            run_burst(blen, 2, $urandom_range(2, 12), blen - pre, 1'b0, 1'b0, "random");
        end
    endtask

    task automatic test_max_len();
        for (int i = 0; i < 255; i++) fifo_write(8'($urandom_range(0, 255)));
        run_burst(255, 0, -1, 0, 1'b0, 1'b1, "max_len");
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        int cyc = 0;
        for (int i = 0; i < 6; i++) fifo_write(8'($urandom_range(0, 255)));
        @(negedge clk);
        start = 1'b1;
        len   = LSIZE'(6);
        while (acc < 2 && cyc < 20) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            m_ready = 1'b1;
            if (m_valid) begin
                checks++;
                if (exp_q.size() == 0 || m_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL reset_mid data: beat %0d got %h", acc, m_data);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                acc++;
            end
            cyc++;
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL reset_mid pre_beats: got %0d required 2", acc);
        end
        @(negedge clk);
        rst     = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        #1;
        check_reset_values("reset_mid");
        rst        = 1'b0;
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) fifo_write(8'($urandom_range(0, 255)));
        run_burst(2, 0, -1, 0, 1'b0, 1'b1, "after_reset");
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        len     = '0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_basic();
        test_zero_len();
        test_stall();
        test_backpressure();
        test_restart();
        test_random();
        test_max_len();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
